// File: rtl/fifo_reader_serializer.sv
// Pulls WIDTH-bit entries from a FIFO dequeue port and re-emits each one as
// NBEATS BEAT-bit beats, LSB first, with back-to-back reload on the last beat.
module fifo_reader_serializer #(
  parameter int WIDTH = 38,
  parameter int BEAT  = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] in_first,
  input  logic             in_first__RDY,
  input  logic             in_deq__RDY,
  output logic             in_deq__ENA,
  output logic [BEAT-1:0]  out_enq_v,
  output logic             out_enq_last,
  input  logic             out_enq__RDY,
  output logic             out_enq__ENA
);

  localparam int NBEATS = (WIDTH + BEAT - 1) / BEAT;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh;
  logic [CNT_W-1:0] cnt;
  logic             up_rdy;
  logic             at_last;
  logic             load;
  logic             advance;
  logic             deq_en;
  logic             enq_en;

  assign up_rdy  = in_first__RDY & in_deq__RDY;
  assign at_last = (cnt == LAST_CNT);

  always_comb begin
    state_nxt = state;
    deq_en    = 1'b0;
    enq_en    = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    unique case (state)
      IDLE: begin
        if (up_rdy) begin
          deq_en    = 1'b1;
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        enq_en = out_enq__RDY;
        if (out_enq__RDY) begin
          if (!at_last) begin
            advance = 1'b1;
          end else if (up_rdy) begin
            // Reload on the final beat so consecutive entries have no bubble.
            deq_en = 1'b1;
            load   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Zero-fill on shift leaves the padding bits of the final beat at zero.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sh  <= '0;
      cnt <= '0;
    end else if (load) begin
      sh  <= in_first;
      cnt <= '0;
    end else if (advance) begin
      sh  <= sh >> BEAT;
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Enables are gated by nRST so they drop the moment reset is asserted.
  assign in_deq__ENA  = deq_en & nRST;
  assign out_enq__ENA = enq_en & nRST;
  assign out_enq_v    = (state == SHIFT) ? sh[BEAT-1:0] : '0;
  assign out_enq_last = (state == SHIFT) & at_last;

endmodule

// File: tb/tb_fifo_reader_serializer.sv
// Bench for fifo_reader_serializer: scenario tasks plus randomized traffic
// checked against a queue-based upstream model and an arithmetic beat model.
module tb_fifo_reader_serializer;

  localparam int W  = 38;
  localparam int B  = 8;
  localparam int NB = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         nrst;
  logic [W-1:0] in_first;
  logic         first_rdy, deq_rdy, deq_ena;
  logic [B-1:0] v;
  logic         last, enq_rdy, enq_ena;

  logic [W-1:0] in_first2;
  logic         first_rdy2, deq_rdy2, deq_ena2;
  logic [W-1:0] v2;
  logic         last2, enq_rdy2, enq_ena2;

  fifo_reader_serializer #(.WIDTH(W), .BEAT(B)) dut (
    .CLK(clk), .nRST(nrst),
    .in_first(in_first), .in_first__RDY(first_rdy), .in_deq__RDY(deq_rdy),
    .in_deq__ENA(deq_ena),
    .out_enq_v(v), .out_enq_last(last), .out_enq__RDY(enq_rdy),
    .out_enq__ENA(enq_ena)
  );

  fifo_reader_serializer #(.WIDTH(W), .BEAT(W)) dut_wide (
    .CLK(clk), .nRST(nrst),
    .in_first(in_first2), .in_first__RDY(first_rdy2), .in_deq__RDY(deq_rdy2),
    .in_deq__ENA(deq_ena2),
    .out_enq_v(v2), .out_enq_last(last2), .out_enq__RDY(enq_rdy2),
    .out_enq__ENA(enq_ena2)
  );

  typedef struct {int cyc; logic [B-1:0] v; logic last;} beat_t;
  typedef struct {int cyc; logic [W-1:0] d;} deq_t;

  beat_t        got_q[$];
  deq_t         deq_q[$];
  logic [W-1:0] up_q[$];
  logic         up_en, deq_rdy_v, enq_rdy_v;
  int           cyc, checks, failures, proto_err;
  logic         smp_deq, smp_enq, smp_last;
  logic [B-1:0] smp_v;

  function automatic logic [B-1:0] exp_beat(input logic [W-1:0] e, input int k);
    logic [63:0] x;
    x = 64'(e);
    x = x / (64'd1 << (k * B));
    return B'(x % (64'd1 << B));
  endfunction

  // One clock: apply drives, sample at negedge, record transfers.
  task automatic tick();
    beat_t bt;
    deq_t  dq;
    in_first  = (up_q.size() > 0) ? up_q[0] : '0;
    first_rdy = up_en && (up_q.size() > 0);
    deq_rdy   = deq_rdy_v;
    enq_rdy   = enq_rdy_v;
    @(negedge clk);
    smp_deq = deq_ena; smp_enq = enq_ena; smp_v = v; smp_last = last;
    if (deq_ena && !(first_rdy && deq_rdy)) proto_err++;
    if (enq_ena && !enq_rdy) proto_err++;
    if (deq_ena) begin
      if (up_q.size() > 0) begin
        dq.cyc = cyc; dq.d = up_q[0];
        deq_q.push_back(dq);
        void'(up_q.pop_front());
      end else begin
        proto_err++;
      end
    end
    if (enq_ena) begin
      bt.cyc = cyc; bt.v = v; bt.last = last;
      got_q.push_back(bt);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rec();
    got_q.delete();
    deq_q.delete();
  endtask

  task automatic test_reset();
    first_rdy = 1'b1; deq_rdy = 1'b1; enq_rdy = 1'b1; in_first = 38'h3F_DEAD_BEEF;
    first_rdy2 = 1'b1; deq_rdy2 = 1'b1; enq_rdy2 = 1'b1; in_first2 = 38'h1;
    #1;
    checks++; if (deq_ena !== 1'b0) begin failures++; $display("FAIL reset_deq_ena got=%b want=0", deq_ena); end
    checks++; if (enq_ena !== 1'b0) begin failures++; $display("FAIL reset_enq_ena got=%b want=0", enq_ena); end
    checks++; if (v !== '0) begin failures++; $display("FAIL reset_v got=%h want=0", v); end
    checks++; if (last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b want=0", last); end
    checks++; if (deq_ena2 !== 1'b0) begin failures++; $display("FAIL reset_wide_deq_ena got=%b want=0", deq_ena2); end
    first_rdy = 1'b0; first_rdy2 = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] want[5];
    want[0] = 8'hEF; want[1] = 8'hBE; want[2] = 8'hAD; want[3] = 8'hDE; want[4] = 8'h3F;
    clear_rec();
    up_en = 1'b1; deq_rdy_v = 1'b1; enq_rdy_v = 1'b1;
    up_q.push_back(38'h3F_DEAD_BEEF);
    repeat (10) tick();
    checks++; if (deq_q.size() !== 1) begin failures++; $display("FAIL single_deq_count got=%0d want=1", deq_q.size()); end
    checks++; if (got_q.size() !== NB) begin failures++; $display("FAIL single_beat_count got=%0d want=%0d", got_q.size(), NB); end
    if (deq_q.size() == 1 && got_q.size() == NB) begin
      for (int k = 0; k < NB; k++) begin
        checks++;
        if (got_q[k].v !== want[k] || got_q[k].last !== (k == NB - 1) ||
            got_q[k].cyc !== deq_q[0].cyc + 1 + k) begin
          failures++;
          $display("FAIL single_beat%0d got=%h/%b@%0d want=%h/%b@%0d", k, got_q[k].v,
                   got_q[k].last, got_q[k].cyc, want[k], (k == NB - 1), deq_q[0].cyc + 1 + k);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] want[10];
    want[0] = 8'h05; want[1] = 8'h04; want[2] = 8'h03; want[3] = 8'h02; want[4] = 8'h01;
    want[5] = 8'h5A; want[6] = 8'h5A; want[7] = 8'hA5; want[8] = 8'hA5; want[9] = 8'h2A;
    clear_rec();
    up_q.push_back(38'h01_0203_0405);
    up_q.push_back(38'h2A_A5A5_5A5A);
    repeat (14) tick();
    checks++; if (deq_q.size() !== 2) begin failures++; $display("FAIL b2b_deq_count got=%0d want=2", deq_q.size()); end
    checks++; if (got_q.size() !== 10) begin failures++; $display("FAIL b2b_beat_count got=%0d want=10", got_q.size()); end
    if (deq_q.size() == 2 && got_q.size() == 10) begin
      for (int k = 0; k < 10; k++) begin
        checks++;
        if (got_q[k].v !== want[k] || got_q[k].last !== (k == 4 || k == 9) ||
            got_q[k].cyc !== got_q[0].cyc + k) begin
          failures++;
          $display("FAIL b2b_beat%0d got=%h/%b@%0d want=%h/%b@%0d", k, got_q[k].v, got_q[k].last,
                   got_q[k].cyc, want[k], (k == 4 || k == 9), got_q[0].cyc + k);
        end
      end
      checks++;
      if (deq_q[1].cyc !== got_q[4].cyc) begin
        failures++; $display("FAIL b2b_second_deq got=%0d want=%0d", deq_q[1].cyc, got_q[4].cyc);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] e2;
    int n;
    e2 = 38'h12_3456_789A;
    clear_rec();
    up_q.push_back(38'h3F_DEAD_BEEF);
    up_q.push_back(e2);
    n = 0;
    while (got_q.size() < 2 && n < 20) begin tick(); n++; end
    checks++; if (got_q.size() !== 2) begin failures++; $display("FAIL bp_reach_beat2 got=%0d want=2", got_q.size()); end
    enq_rdy_v = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      checks++;
      if (smp_v !== 8'hAD || smp_enq !== 1'b0 || smp_deq !== 1'b0) begin
        failures++;
        $display("FAIL bp_stall%0d got v=%h enq=%b deq=%b want v=ad enq=0 deq=0", s, smp_v, smp_enq, smp_deq);
      end
    end
    enq_rdy_v = 1'b1;
    repeat (20) tick();
    checks++; if (deq_q.size() !== 2) begin failures++; $display("FAIL bp_deq_count got=%0d want=2", deq_q.size()); end
    checks++; if (got_q.size() !== 2 * NB) begin failures++; $display("FAIL bp_beat_count got=%0d want=%0d", got_q.size(), 2 * NB); end
    if (got_q.size() == 2 * NB && deq_q.size() == 2) begin
      for (int k = 0; k < 2 * NB; k++) begin
        checks++;
        if (got_q[k].v !== exp_beat((k < NB) ? 38'h3F_DEAD_BEEF : e2, k % NB) ||
            got_q[k].last !== (k % NB == NB - 1)) begin
          failures++;
          $display("FAIL bp_beat%0d got=%h/%b want=%h/%b", k, got_q[k].v, got_q[k].last,
                   exp_beat((k < NB) ? 38'h3F_DEAD_BEEF : e2, k % NB), (k % NB == NB - 1));
        end
      end
    end
  endtask

  task automatic test_empty();
    logic [W-1:0] e;
    e = W'({$urandom, $urandom});
    clear_rec();
    up_en = 1'b0;
    up_q.push_back(e);
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (smp_deq !== 1'b0 || smp_enq !== 1'b0 || smp_v !== '0 || smp_last !== 1'b0) begin
        failures++;
        $display("FAIL empty_cycle%0d got deq=%b enq=%b v=%h last=%b want all 0", c, smp_deq, smp_enq, smp_v, smp_last);
      end
    end
    up_en = 1'b1;
    tick();
    checks++; if (smp_deq !== 1'b1) begin failures++; $display("FAIL empty_take got=%b want=1", smp_deq); end
    repeat (8) tick();
    checks++; if (got_q.size() !== NB) begin failures++; $display("FAIL empty_beat_count got=%0d want=%0d", got_q.size(), NB); end
    if (got_q.size() == NB && deq_q.size() == 1) begin
      checks++;
      if (got_q[0].cyc !== deq_q[0].cyc + 1) begin
        failures++; $display("FAIL empty_latency got=%0d want=%0d", got_q[0].cyc, deq_q[0].cyc + 1);
      end
      for (int k = 0; k < NB; k++) begin
        checks++;
        if (got_q[k].v !== exp_beat(e, k)) begin
          failures++; $display("FAIL empty_beat%0d got=%h want=%h", k, got_q[k].v, exp_beat(e, k));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] e1, e2;
    int n;
    e1 = W'({$urandom, $urandom});
    e2 = W'({$urandom, $urandom});
    clear_rec();
    up_q.push_back(e1);
    up_q.push_back(e2);
    n = 0;
    while (got_q.size() < 2 && n < 20) begin tick(); n++; end
    checks++; if (got_q.size() !== 2) begin failures++; $display("FAIL rmid_reach_beat2 got=%0d want=2", got_q.size()); end
    #2 nrst = 1'b0;
    #1;
    checks++;
    if (deq_ena !== 1'b0 || enq_ena !== 1'b0 || v !== '0 || last !== 1'b0) begin
      failures++;
      $display("FAIL rmid_async got deq=%b enq=%b v=%h last=%b want all 0", deq_ena, enq_ena, v, last);
    end
    @(posedge clk); #1;
    checks++;
    if (deq_ena !== 1'b0 || enq_ena !== 1'b0) begin
      failures++; $display("FAIL rmid_held got deq=%b enq=%b want 0 0", deq_ena, enq_ena);
    end
    nrst = 1'b1;
    clear_rec();
    repeat (10) tick();
    checks++;
    if (deq_q.size() !== 1 || (deq_q.size() == 1 && deq_q[0].d !== e2)) begin
      failures++; $display("FAIL rmid_deq got count=%0d want 1 entry %h", deq_q.size(), e2);
    end
    checks++; if (got_q.size() !== NB) begin failures++; $display("FAIL rmid_beat_count got=%0d want=%0d", got_q.size(), NB); end
    if (got_q.size() == NB) begin
      for (int k = 0; k < NB; k++) begin
        checks++;
        if (got_q[k].v !== exp_beat(e2, k) || got_q[k].last !== (k == NB - 1)) begin
          failures++;
          $display("FAIL rmid_beat%0d got=%h/%b want=%h/%b", k, got_q[k].v, got_q[k].last, exp_beat(e2, k), (k == NB - 1));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] sent[$];
    logic [W-1:0] e;
    int n, bi;
    clear_rec();
    for (int i = 0; i < 8; i++) begin
      e = W'({$urandom, $urandom});
      sent.push_back(e);
      up_q.push_back(e);
    end
    n = 0;
    while (got_q.size() < 8 * NB && n < 600) begin
      up_en     = ($urandom % 3) != 0;
      deq_rdy_v = ($urandom % 4) != 0;
      enq_rdy_v = ($urandom % 3) != 0;
      tick();
      n++;
    end
    up_en = 1'b1; deq_rdy_v = 1'b1; enq_rdy_v = 1'b1;
    repeat (2) tick();
    checks++; if (got_q.size() !== 8 * NB) begin failures++; $display("FAIL rand_beat_count got=%0d want=%0d", got_q.size(), 8 * NB); end
    checks++; if (deq_q.size() !== 8) begin failures++; $display("FAIL rand_deq_count got=%0d want=8", deq_q.size()); end
    if (deq_q.size() == 8 && got_q.size() == 8 * NB) begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (deq_q[i].d !== sent[i]) begin
          failures++; $display("FAIL rand_deq%0d got=%h want=%h", i, deq_q[i].d, sent[i]);
        end
        for (int k = 0; k < NB; k++) begin
          bi = i * NB + k;
          checks++;
          if (got_q[bi].v !== exp_beat(sent[i], k) || got_q[bi].last !== (k == NB - 1)) begin
            failures++;
            $display("FAIL rand_beat%0d got=%h/%b want=%h/%b", bi, got_q[bi].v, got_q[bi].last,
                     exp_beat(sent[i], k), (k == NB - 1));
          end
        end
      end
    end
  endtask

  task automatic test_beat38();
    logic [W-1:0] ents[3];
    logic [W-1:0] bv[$];
    logic         bl[$];
    int           dcyc[$], bcyc[$];
    int           idx;
    ents[0] = 38'h1; ents[1] = 38'h2; ents[2] = 38'h3;
    idx = 0;
    enq_rdy2 = 1'b1; deq_rdy2 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      first_rdy2 = (idx < 3);
      in_first2  = (idx < 3) ? ents[idx] : '0;
      @(negedge clk);
      if (deq_ena2) begin dcyc.push_back(c); idx++; end
      if (enq_ena2) begin bcyc.push_back(c); bv.push_back(v2); bl.push_back(last2); end
      @(posedge clk); #1;
    end
    first_rdy2 = 1'b0;
    checks++; if (dcyc.size() !== 3) begin failures++; $display("FAIL wide_deq_count got=%0d want=3", dcyc.size()); end
    checks++; if (bv.size() !== 3) begin failures++; $display("FAIL wide_beat_count got=%0d want=3", bv.size()); end
    if (dcyc.size() == 3 && bv.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (bv[k] !== ents[k] || bl[k] !== 1'b1 || bcyc[k] !== dcyc[k] + 1 || dcyc[k] !== dcyc[0] + k) begin
          failures++;
          $display("FAIL wide_beat%0d got=%h/%b@%0d want=%h/1@%0d", k, bv[k], bl[k], bcyc[k], ents[k], dcyc[k] + 1);
        end
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0; proto_err = 0; cyc = 0;
    nrst = 1'b0;
    in_first = '0; first_rdy = 1'b0; deq_rdy = 1'b0; enq_rdy = 1'b0;
    in_first2 = '0; first_rdy2 = 1'b0; deq_rdy2 = 1'b0; enq_rdy2 = 1'b0;
    up_en = 1'b0; deq_rdy_v = 1'b1; enq_rdy_v = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_empty();
    test_reset_mid();
    test_random();
    test_beat38();
    checks++;
    if (proto_err !== 0) begin failures++; $display("FAIL handshake_rules got=%0d violations want=0", proto_err); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
